// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: write-request struct, arbiter state, XLEN
package core_pkg;

  localparam int XLEN = 32;

  // Register-file write request; rd is the destination register.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    MEM_PRI  = 1'b0,
    MD_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - 64-bit enable-increment counter, also used for CSR instret
module retire_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [63:0] count
);

  // Wraps from all-ones to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter, mem vs mul/div; WB_STARVE_GUARD_EN enables md anti-starvation
module wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [4:0]      mem_reg,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_stall,
  input  logic            md_valid,
  input  logic [XLEN-1:0] md_pc,
  input  logic [4:0]      md_reg,
  input  logic [XLEN-1:0] md_data,
  output logic            md_stall,
  output logic [4:0]      wreg,
  output logic [XLEN-1:0] wdata,
  output logic            wen,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic [63:0]     retire_count
);

  wb_req_t mem_req;
  wb_req_t md_req;
  wb_req_t win;
  logic    mem_acc;
  logic    md_acc;
  logic    acc;

  assign mem_req = '{valid: mem_valid, pc: mem_pc, rd: mem_reg, data: mem_data};
  assign md_req  = '{valid: md_valid, pc: md_pc, rd: md_reg, data: md_data};

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] starve_cnt;

  always_comb begin
    mem_stall = mem_req.valid & md_req.valid & (state == MD_FORCE);
    md_stall  = md_req.valid & mem_req.valid & (state == MEM_PRI);
  end

  // Enter MD_FORCE on the edge where the stalled count reaches LIMIT, so md
  // wins on cycle LIMIT+1. MD_FORCE lasts one cycle: md either wins or left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MEM_PRI;
      starve_cnt <= '0;
    end else begin
      case (state)
        MEM_PRI: begin
          if (md_stall) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
            if (({1'b0, starve_cnt} + 5'd1) >= {1'b0, LIMIT}) state <= MD_FORCE;
          end else begin
            starve_cnt <= '0;
          end
        end
        default: begin
          state      <= MEM_PRI;
          starve_cnt <= '0;
        end
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = |4'(STARVE_LIMIT);

  always_comb begin
    mem_stall = 1'b0;
    md_stall  = md_req.valid & mem_req.valid;
  end
`endif

  assign mem_acc = mem_req.valid & ~mem_stall;
  assign md_acc  = md_req.valid & ~md_stall;
  assign acc     = mem_acc | md_acc;
  assign win     = mem_acc ? mem_req : md_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wreg         <= '0;
      wdata        <= '0;
      wen          <= 1'b0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
    end else if (acc) begin
      wreg         <= win.rd;
      wdata        <= win.data;
      wen          <= (win.rd != 5'd0);
      retire_valid <= 1'b1;
      retire_pc    <= win.pc;
    end else begin
      wen          <= 1'b0;
      retire_valid <= 1'b0;
    end
  end

  retire_counter u_retire (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (acc),
    .count   (retire_count)
  );

endmodule
